// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder controller: FSM state encoding and default width.
package serial_add_pkg;

  localparam int SERIAL_ADD_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/fulladder.sv
// 1-bit combinational full-adder cell shared by the serial adder datapath.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: sequences one full-adder cell over WIDTH cycles, LSB first.
// Optional subtract mode (sub port) is built when SERIAL_ADD_SUB_EN is defined.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output state_t           state_o
);

  // Handshake: start is sampled only in IDLE; done is a one-cycle result-valid
  // pulse; busy covers the whole operation from the accepting edge until the
  // edge after done, so a new start is accepted one cycle after done.

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] TERM_CNT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             fa_sum;
  logic             fa_cout;

`ifdef SERIAL_ADD_SUB_EN
  // a - b as a + ~b + 1; the carry-out then reads as "no borrow".
  assign b_load = sub ? ~b : b;
  assign c_load = sub | cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  fulladder u_fa (
    .a   (a_sr_q[0]),
    .b   (b_sr_q[0]),
    .cin (carry_q),
    .sum (fa_sum),
    .cout(fa_cout)
  );

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    sum_d    = sum_q;
    cout_d   = cout_q;

    case (state_q)
      ST_IDLE: begin
        busy_d = start;
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b_load;
          carry_d = c_load;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy_d   = 1'b1;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        sum_sr_d = {fa_sum, sum_sr_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == TERM_CNT) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b1;
        done_d  = 1'b1;
        sum_d   = sum_sr_q;
        cout_d  = carry_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign sum     = sum_q;
  assign cout    = cout_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: randomized operations against an arithmetic reference,
// with a result/latency scoreboard fed at acceptance and drained by a done monitor.
module tb_serial_add_ctrl;
  import serial_add_pkg::*;

  localparam int W = 8;
`ifdef SERIAL_ADD_SUB_EN
  localparam bit HAS_SUB = 1'b1;
`else
  localparam bit HAS_SUB = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  state_t       state_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [W:0] exp_q[$];
  int         cyc_q[$];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .cin    (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub    (sub),
`endif
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .cout   (cout),
    .state_o(state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W:0] model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                       input logic cc, input logic ss);
    int r;
    if (ss) r = int'(aa) + (1 << W) - int'(bb);
    else    r = int'(aa) + int'(bb) + int'(cc);
    return (W+1)'(r);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: every done must match the oldest outstanding expectation, on time
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done at cycle %0d with nothing outstanding", cyc);
      end else begin
        logic [W:0] e;
        int         ec;
        e  = exp_q.pop_front();
        ec = cyc_q.pop_front();
        chk("result", {cout, sum}, e);
        chk("done_cycle", cyc, ec);
      end
    end
  end

  // driver: one accepted operation, then wait out its WIDTH+2 cycle slot
  task automatic issue(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic cc,
                       input logic ss, input bit noise, input bit chk_busy);
    int nb;
    logic s_eff;
    s_eff = ss & HAS_SUB;
    start = 1'b1;
    a = aa;
    b = bb;
    cin = cc;
`ifdef SERIAL_ADD_SUB_EN
    sub = s_eff;
`endif
    @(posedge clk);
    @(negedge clk);
    exp_q.push_back(model(aa, bb, cc, s_eff));
    cyc_q.push_back(cyc + W + 1);
    start = 1'b0;
    nb = busy ? 1 : 0;
    for (int i = 0; i < W + 1; i++) begin
      start = noise;
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      sub = 1'($urandom);
`endif
      @(negedge clk);
      if (busy) nb++;
    end
    start = 1'b0;
    if (chk_busy) chk("busy_len", nb, W + 2);
  endtask

  task automatic back_to_back(input int n);
    start = 1'b1;
    a = 8'h80;
    b = 8'h80;
    cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      exp_q.push_back(model(8'h80, 8'h80, 1'b0, 1'b0));
      cyc_q.push_back(cyc + W + 1);
      repeat (W + 1) @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    checks++;
    errors++;
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_state", state_o, ST_IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    // basic add with busy length and release
    issue(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("busy_release", busy, 0);

    // carry ripple
    issue(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);

    // start held while busy, then idle long enough to expose a spurious second done
    issue(8'h21, 8'h43, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2 * W) @(negedge clk);
    chk("idle_after_ignored_start", busy, 0);

    // reset on the 4th RUN edge discards the operation
    start = 1'b1;
    a = 8'h77;
    b = 8'h11;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrun_rst_state", state_o, ST_IDLE);
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_done", done, 0);
    chk("midrun_rst_sum", sum, 0);
    chk("midrun_rst_cout", cout, 0);
    rst_n = 1'b1;
    @(negedge clk);
    issue(8'h10, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0);

    back_to_back(3);

    if (HAS_SUB) begin
      issue(8'h10, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
      issue(8'h01, 8'h02, 1'b1, 1'b1, 1'b0, 1'b0);
    end

    for (int i = 0; i < 20; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (W + 4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
